// File: rtl/up_down_counter_mod.sv
// Modulo-N up/down counter with parallel load, terminal count and wrap pulse.
// Define UP_DOWN_COUNTER_SATURATE_EN to make the count saturate at its ends instead of wrapping.
module up_down_counter_mod #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

`ifdef UP_DOWN_COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;

    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_load_sat;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_ovf_nxt;

    assign w_at_max   = (r_q == MAX_VAL);
    assign w_at_zero  = (r_q == '0);
    // Out-of-range load values clamp to the top of the count range.
    assign w_load_sat = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

    always_comb begin
        w_q_nxt   = r_q;
        w_ovf_nxt = 1'b0;
        if (load) begin
            w_q_nxt = w_load_sat;
        end else if (en) begin
            if (dir) begin
                if (w_at_max) begin
                    w_q_nxt   = SATURATE ? MAX_VAL : '0;
                    w_ovf_nxt = ~SATURATE;
                end else begin
                    w_q_nxt = r_q + ONE;
                end
            end else begin
                if (w_at_zero) begin
                    w_q_nxt   = SATURATE ? '0 : MAX_VAL;
                    w_ovf_nxt = ~SATURATE;
                end else begin
                    w_q_nxt = r_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;
    assign ovf  = r_ovf;
    assign tc   = (dir & w_at_max) | (~dir & w_at_zero);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed plus random checks of up_down_counter_mod at MODULUS=10 and MODULUS=16 (WIDTH=4).
// Expected results come from a behavioural model and are queued per step, then compared after the edge.
module tb_up_down_counter_mod;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] q10, qbar10, q16, qbar16;
    logic       tc10, ovf10, tc16, ovf16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int q10;
        bit o10;
        int q16;
        bit o16;
    } exp_t;

    exp_t sb[$];
    int   m10 = 0;
    int   m16 = 0;
    bit   m_valid = 1'b0;

    always #5 clk = ~clk;

    up_down_counter_mod #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk(clk), .clr(clr), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .q(q10), .qbar(qbar10), .tc(tc10), .ovf(ovf10)
    );

    up_down_counter_mod #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk(clk), .clr(clr), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .q(q16), .qbar(qbar16), .tc(tc16), .ovf(ovf16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns next count in bits [7:0], wrap pulse in bit 8.
    function automatic int model(input int mod, input int cur, input bit c, input bit l,
                                 input bit e, input bit d, input int lv);
        int  nq;
        bit  o;
        nq = cur;
        o  = 1'b0;
        if (c) begin
            nq = 0;
        end else if (l) begin
            nq = (lv < mod) ? lv : mod - 1;
        end else if (e) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
            if (d) nq = (cur == mod - 1) ? cur : cur + 1;
            else   nq = (cur == 0) ? 0 : cur - 1;
`else
            if (d) begin
                if (cur == mod - 1) begin nq = 0; o = 1'b1; end
                else nq = cur + 1;
            end else begin
                if (cur == 0) begin nq = mod - 1; o = 1'b1; end
                else nq = cur - 1;
            end
`endif
        end
        return (int'(o) << 8) | nq;
    endfunction

    task automatic step(input bit c, input bit l, input int lv, input bit e, input bit d);
        exp_t x;
        int   r;
        @(negedge clk);
        clr = c; load = l; load_val = 4'(lv); en = e; dir = d;
        #1;
        if (m_valid) begin
            check("tc10", 32'(tc10), 32'(d ? (m10 == 9) : (m10 == 0)));
            check("tc16", 32'(tc16), 32'(d ? (m16 == 15) : (m16 == 0)));
        end
        r = model(10, m10, c, l, e, d, lv); x.q10 = r & 8'hFF; x.o10 = r[8];
        r = model(16, m16, c, l, e, d, lv); x.q16 = r & 8'hFF; x.o16 = r[8];
        m10 = x.q10;
        m16 = x.q16;
        if (c) m_valid = 1'b1;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (m_valid) begin
            check("q10",    32'(q10),    32'(x.q10));
            check("ovf10",  32'(ovf10),  32'(x.o10));
            check("qbar10", 32'(qbar10), 32'((~x.q10) & 4'hF));
            check("q16",    32'(q16),    32'(x.q16));
            check("ovf16",  32'(ovf16),  32'(x.o16));
            check("qbar16", 32'(qbar16), 32'((~x.q16) & 4'hF));
        end
    endtask

    initial begin
        // Reset, then count up across the MODULUS=10 boundary.
        step(1, 0, 0, 0, 1);
        check("rst_q10_zero", 32'(q10), 32'd0);
        check("rst_qbar10_ones", 32'(qbar10), 32'hF);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);
        // Count down from zero, wrap to 9.
        step(1, 0, 0, 0, 0);
        check("tc10_at_zero_down", 32'(tc10), 32'd1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
        // Load clamping and load-over-enable priority.
        step(0, 1, 12, 0, 1);
        check("load_clamp_q10", 32'(q10), 32'd9);
        step(0, 1, 3, 1, 1);
        check("load_beats_en_q10", 32'(q10), 32'd3);
        // clr at a boundary step, then toggle dir each cycle.
        step(0, 1, 9, 0, 1);
        step(1, 0, 0, 1, 1);
        check("clr_boundary_ovf10", 32'(ovf10), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, (i % 2) == 0);
        // Load at a boundary step suppresses the wrap.
        step(0, 1, 9, 0, 1);
        step(0, 1, 5, 1, 1);
        check("load_boundary_ovf10", 32'(ovf10), 32'd0);
        // Full-range wrap at MODULUS=16.
        step(0, 1, 15, 0, 1);
        step(0, 0, 0, 1, 1);
        // Long up and down runs to exercise saturation when enabled.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1);
        step(0, 1, 9, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0);
        // Random mix.
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod.md
UP_DOWN_COUNTER_MOD -- requirements
Module: up_down_counter_mod

Interface
- REQ-001 Parameter WIDTH, default 4: counter width in bits, legal 2..32.
- REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1, legal 2..2^WIDTH.
- REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
- REQ-004 Port clr, input, 1: synchronous, active-high reset; one clock, no other reset.
- REQ-005 Port en, input, 1: count enable; 1 = step once per clock.
- REQ-006 Port dir, input, 1: direction; 1 = up, 0 = down.
- REQ-007 Port load, input, 1: synchronous parallel load strobe.
- REQ-008 Port load_val, input, WIDTH: value captured on load.
- REQ-009 Port q, output, WIDTH: registered count.
- REQ-010 Port qbar, output, WIDTH: bitwise complement of q.
- REQ-011 Port tc, output, 1: combinational terminal count.
- REQ-012 Port ovf, output, 1: registered one-cycle wrap pulse.

Function
- REQ-013 Per-edge priority: clr > load > en; en=0 with no clr or load holds q.
- REQ-014 Load: q <= load_val if load_val < MODULUS, else MODULUS-1; independent of en and dir.
- REQ-015 Up step (en=1, dir=1): q <= q+1; at q==MODULUS-1, q <= 0.
- REQ-016 Down step (en=1, dir=0): q <= q-1; at q==0, q <= MODULUS-1.
- REQ-017 tc = (dir & q==MODULUS-1) | (~dir & q==0); independent of en; follows dir combinationally.
- REQ-018 ovf = 1 for exactly the cycle after an enabled step that wrapped (REQ-015/016 boundary); 0 otherwise.
- REQ-019 Load or clr in the same cycle as a boundary step: no wrap; ovf = 0 the next cycle.
- REQ-020 dir may change any cycle; the step uses dir sampled at that edge; no dead cycle.
- REQ-021 MODULUS = 2^WIDTH: wrap is natural binary overflow; behaviour otherwise identical.
- REQ-022 q never leaves 0..MODULUS-1 after the first clr.
- REQ-023 Latency: q reflects load or step one clock after the sampling edge; tc has zero cycles of latency from q and dir.

Reset
- REQ-024 clr=1 at an edge: q <= 0, ovf <= 0, qbar = all ones; tc = ~dir (q=0).
- REQ-025 clr mid-count overrides load and en in that cycle; counting resumes the first edge after clr deasserts.
- REQ-026 Before the first clr, output values are undefined; the bench checks only after reset.

Configuration
- REQ-027 Macro UP_DOWN_COUNTER_SATURATE_EN selects saturating mode.
- REQ-028 Macro defined: an up step at MODULUS-1 holds MODULUS-1 and a down step at 0 holds 0; ovf is tied to 0; tc, load and clr are unchanged.
- REQ-029 Macro undefined: wrap behaviour per REQ-015 to REQ-018.

Verification
- REQ-030 WIDTH=4, MODULUS=10, clr, then en=1, dir=1 for 12 clocks -> q goes 0..9,0,1; tc high at q=9; ovf high the cycle q=0 follows 9.
- REQ-031 MODULUS=10, clr, then en=1, dir=0 -> q goes 0,9,8...; tc high at q=0 before the first step; ovf pulses once as q becomes 9.
- REQ-032 load=1 with load_val=12, MODULUS=10 -> q=9; load=1 and en=1 together with load_val=3 -> q=3, no step.
- REQ-033 q=9, dir=1, en=1, clr=1 at the same edge -> q=0, ovf=0 the next cycle; then toggle dir each cycle -> q alternates 1,0,1...
- REQ-034 UP_DOWN_COUNTER_SATURATE_EN defined, MODULUS=10 -> count up from 0 for 15 clocks holds at 9, ovf never 1; count down from 9 for 15 clocks holds at 0.
- REQ-035 WIDTH=4, MODULUS=16 -> up from 15 wraps to 0 with ovf; qbar == ~q checked every cycle.
